ah_range_encoder_34_10: RTL and testbench

Initiator-side range encoder and arbiter: collects access requests from up to 10 local clients, each carrying a 12-bit offset into its own 4 KiB window. It selects one request per cycle with round-robin arbitration and emits a registered 34-bit packet field plus a valid/ready handshake toward the fabric. Encoding is the exact inverse of the decoder's range map. A field emitted for client i decodes back to one-hot bit i with no decode error.

---
 rtl/ah_range_enc_pkg.sv | 24 ++
 rtl/ah_rr_arbiter.sv | 41 ++++
 rtl/ah_range_encoder_34_10.sv | 93 +++++++++
 tb/tb_ah_range_encoder_34_10.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ah_range_enc_pkg.sv
// rtl/ah_range_enc_pkg.sv - shared constants, window-base helper and encoder state type
//
// Purpose: a single place for the encoder's sizing constants and the window map.
//          The decoder's range constants also come from win_base(), so both ends
//          agree on where each client window starts.
// Contents: NUM_CLIENTS, OFF_W, IDX_W, ADDR_W, win_base(), enc_state_t.
package ah_range_enc_pkg;

  localparam int NUM_CLIENTS = 10;
  localparam int OFF_W       = 12;
  localparam int IDX_W       = 4;
  localparam int ADDR_W      = 34;

  // Client i owns [i<<OFF_W, ((i+1)<<OFF_W)-1]. The bits above IDX_W+OFF_W stay zero.
  function automatic logic [ADDR_W-1:0] win_base(input logic [IDX_W-1:0] idx);
    return ADDR_W'(idx) << OFF_W;
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } enc_state_t;

endpackage

// File: rtl/ah_rr_arbiter.sv
// rtl/ah_rr_arbiter.sv - combinational round-robin winner select
//
// Purpose: picks the first eligible client, scanning from last_idx+1 and wrapping
//          modulo NUM_CLIENTS. The pointer register is held by the parent.
// Ports:
//   eligible  in   requests that may be granted this cycle
//   last_idx  in   most recently granted client
//   advance   in   arbitration allowed (output slot free)
//   win_oh    out  one-hot winner
//   win_idx   out  winner index
//   any_win   out  a winner exists and advance is high
module ah_rr_arbiter
  import ah_range_enc_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] eligible,
  input  logic [IDX_W-1:0]       last_idx,
  input  logic                   advance,
  output logic [NUM_CLIENTS-1:0] win_oh,
  output logic [IDX_W-1:0]       win_idx,
  output logic                   any_win
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any_win = 1'b0;
    cand    = '0;
    // k runs from 1 to NUM_CLIENTS, so the last candidate checked is last_idx itself.
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      cand = IDX_W'((int'(last_idx) + k) % NUM_CLIENTS);
      if (advance && !any_win && eligible[cand]) begin
        win_oh[cand] = 1'b1;
        win_idx      = cand;
        any_win      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ah_range_encoder_34_10.sv
// rtl/ah_range_encoder_34_10.sv - round-robin request arbiter and 34-bit range encoder
//
// Purpose: grants one of NUM_CLIENTS requests per cycle and places the encoded address
//          {idx, offset} in a single-entry registered output slot with a valid/ready handshake.
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   client_req         level request per client, held until granted
//   client_offset      OFF_W-bit offset per client, packed at [i*OFF_W +: OFF_W]
//   client_en          enable mask; a disabled client is granted but its request is dropped
//   client_gnt         one-hot grant pulse, one cycle long
//   egress_pkt_field   encoded address, zero-extended to ADDR_W
//   egress_client_idx  owner of egress_pkt_field
//   egress_valid       slot full
//   egress_ready       fabric accepts when valid && ready
//   enc_err            one-cycle pulse when a disabled client is granted
module ah_range_encoder_34_10
  import ah_range_enc_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CLIENTS-1:0]       client_req,
  input  logic [NUM_CLIENTS*OFF_W-1:0] client_offset,
  input  logic [NUM_CLIENTS-1:0]       client_en,
  output logic [NUM_CLIENTS-1:0]       client_gnt,
  output logic [ADDR_W-1:0]            egress_pkt_field,
  output logic [IDX_W-1:0]             egress_client_idx,
  output logic                         egress_valid,
  input  logic                         egress_ready,
  output logic                         enc_err
);

  enc_state_t             state;
  logic [IDX_W-1:0]       last_idx;
  logic                   slot_free;
  logic [NUM_CLIENTS-1:0] eligible;
  logic [NUM_CLIENTS-1:0] win_oh;
  logic [IDX_W-1:0]       win_idx;
  logic                   any_win;
  logic [OFF_W-1:0]       off_arr [NUM_CLIENTS];

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_off
    assign off_arr[g] = client_offset[g*OFF_W +: OFF_W];
  end

  assign egress_valid = (state == FULL);
  assign slot_free    = (state == EMPTY) || egress_ready;
  // Masking with the current grant stops a client whose req is still high in its
  // grant cycle from being granted a second time.
  assign eligible     = client_req & ~client_gnt;

  ah_rr_arbiter u_arb (
    .eligible (eligible),
    .last_idx (last_idx),
    .advance  (slot_free),
    .win_oh   (win_oh),
    .win_idx  (win_idx),
    .any_win  (any_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= EMPTY;
      last_idx          <= IDX_W'(NUM_CLIENTS - 1);
      client_gnt        <= '0;
      egress_pkt_field  <= '0;
      egress_client_idx <= '0;
      enc_err           <= 1'b0;
    end else begin
      client_gnt <= '0;
      enc_err    <= 1'b0;
      if (slot_free) begin
        if (any_win) begin
          client_gnt <= win_oh;
          last_idx   <= win_idx;
          if (client_en[win_idx]) begin
            egress_pkt_field  <= win_base(win_idx) | ADDR_W'(off_arr[win_idx]);
            egress_client_idx <= win_idx;
            state             <= FULL;
          end else begin
            // The slot is free here, so it was either empty or drained this cycle.
            // Either way nothing is left in it.
            enc_err <= 1'b1;
            state   <= EMPTY;
          end
        end else begin
          state <= EMPTY;
        end
      end
      // While stalled, the field, index, valid and pointer all keep their values.
    end
  end

endmodule

// File: tb/tb_ah_range_encoder_34_10.sv
// tb/tb_ah_range_encoder_34_10.sv - directed self-checking bench for ah_range_encoder_34_10
module tb_ah_range_encoder_34_10;
  import ah_range_enc_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_CLIENTS-1:0]       client_req;
  logic [NUM_CLIENTS*OFF_W-1:0] client_offset;
  logic [NUM_CLIENTS-1:0]       client_en;
  logic [NUM_CLIENTS-1:0]       client_gnt;
  logic [ADDR_W-1:0]            egress_pkt_field;
  logic [IDX_W-1:0]             egress_client_idx;
  logic                         egress_valid;
  logic                         egress_ready;
  logic                         enc_err;

  int pass_cnt = 0;
  int fail_cnt = 0;

  logic [NUM_CLIENTS-1:0] dec;
  logic                   dec_err;
  logic [ADDR_W-1:0]      exp_f;

  always #5 clk = ~clk;

  ah_range_encoder_34_10 dut (
    .clk               (clk),
    .rst               (rst),
    .client_req        (client_req),
    .client_offset     (client_offset),
    .client_en         (client_en),
    .client_gnt        (client_gnt),
    .egress_pkt_field  (egress_pkt_field),
    .egress_client_idx (egress_client_idx),
    .egress_valid      (egress_valid),
    .egress_ready      (egress_ready),
    .enc_err           (enc_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_off(input int i, input logic [OFF_W-1:0] v);
    client_offset[i*OFF_W +: OFF_W] = v;
  endtask

  // Reference decoder: the inverse range map, written independently from the constants.
  task automatic decode(input logic [ADDR_W-1:0] f);
    dec     = '0;
    dec_err = 1'b0;
    if (f[ADDR_W-1:16] != 0 || f[15:12] >= 4'd10) dec_err = 1'b1;
    else dec[f[15:12]] = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    client_req = '0;
    client_offset = '0;
    client_en = '1;
    egress_ready = 1'b1;
    for (int i = 0; i < NUM_CLIENTS; i++) set_off(i, OFF_W'(i * 'h111));
    tick(); tick();
    chk("rst_gnt", 64'(client_gnt), 64'h0);
    chk("rst_valid", 64'(egress_valid), 64'h0);
    chk("rst_field", 64'(egress_pkt_field), 64'h0);
    chk("rst_idx", 64'(egress_client_idx), 64'h0);
    chk("rst_err", 64'(enc_err), 64'h0);

    // Single request, client 3, offset 0x0A5.
    rst = 1'b0;
    set_off(3, 12'h0A5);
    client_req = 10'h008;
    tick();
    chk("c3_gnt", 64'(client_gnt), 64'h008);
    chk("c3_field", 64'(egress_pkt_field), 64'h0000030A5);
    chk("c3_idx", 64'(egress_client_idx), 64'd3);
    chk("c3_valid", 64'(egress_valid), 64'h1);
    tick();
    chk("c3_no_regrant", 64'(client_gnt), 64'h0);
    chk("c3_drained", 64'(egress_valid), 64'h0);
    client_req = '0;
    set_off(3, 12'h333);

    // All clients requesting from a fresh pointer: 0..9,0 with no gaps.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    client_req = '1;
    for (int k = 0; k < 11; k++) begin
      tick();
      exp_f = (ADDR_W'(k % 10) << 12) | ADDR_W'((k % 10) * 'h111);
      chk($sformatf("rr_gnt_%0d", k), 64'(client_gnt), 64'(10'h001 << (k % 10)));
      chk($sformatf("rr_field_%0d", k), 64'(egress_pkt_field), 64'(exp_f));
      chk($sformatf("rr_valid_%0d", k), 64'(egress_valid), 64'h1);
      decode(egress_pkt_field);
      chk($sformatf("rr_dec_%0d", k), 64'(dec), 64'(10'h001 << (k % 10)));
    end
    client_req = '0;
    tick();
    chk("rr_end_valid", 64'(egress_valid), 64'h0);

    // Stall: client 5 held in the slot while client 6 waits.
    client_req = 10'h020;
    egress_ready = 1'b0;
    tick();
    chk("st_gnt5", 64'(client_gnt), 64'h020);
    chk("st_field5", 64'(egress_pkt_field), 64'h000005555);
    client_req = 10'h040;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("st_hold_gnt_%0d", k), 64'(client_gnt), 64'h0);
      chk($sformatf("st_hold_field_%0d", k), 64'(egress_pkt_field), 64'h000005555);
      chk($sformatf("st_hold_valid_%0d", k), 64'(egress_valid), 64'h1);
    end
    egress_ready = 1'b1;
    tick();
    chk("st_gnt6", 64'(client_gnt), 64'h040);
    chk("st_field6", 64'(egress_pkt_field), 64'h000006666);
    chk("st_idx6", 64'(egress_client_idx), 64'd6);
    chk("st_valid6", 64'(egress_valid), 64'h1);
    client_req = '0;
    tick();
    chk("st_end_valid", 64'(egress_valid), 64'h0);

    // Disabled client 2: granted, flagged, nothing loaded; pointer moves to 2.
    client_en = 10'h3FB;
    client_req = 10'h004;
    tick();
    chk("dis_gnt", 64'(client_gnt), 64'h004);
    chk("dis_err", 64'(enc_err), 64'h1);
    chk("dis_valid", 64'(egress_valid), 64'h0);
    client_req = '0;
    tick();
    chk("dis_err_clr", 64'(enc_err), 64'h0);
    // With the pointer at 2, client 3 wins over client 2; a pointer left at 6 would pick 2.
    client_req = 10'h00C;
    tick();
    chk("dis_ptr_gnt", 64'(client_gnt), 64'h008);
    chk("dis_ptr_field", 64'(egress_pkt_field), 64'h000003333);
    client_req = '0;
    client_en = '1;
    tick();

    // Top offset of the last window.
    set_off(9, 12'hFFF);
    client_req = 10'h200;
    tick();
    chk("max_field", 64'(egress_pkt_field), 64'h000009FFF);
    chk("max_idx", 64'(egress_client_idx), 64'd9);
    decode(egress_pkt_field);
    chk("max_dec", 64'(dec), 64'h200);
    chk("max_dec_err", 64'(dec_err), 64'h0);
    client_req = '0;
    egress_ready = 1'b0;
    tick();
    chk("max_hold_valid", 64'(egress_valid), 64'h1);
    chk("max_hold_field", 64'(egress_pkt_field), 64'h000009FFF);

    // Reset while full and stalled, with requests pending.
    rst = 1'b1;
    client_req = 10'h0F0;
    tick();
    chk("mrst_valid", 64'(egress_valid), 64'h0);
    chk("mrst_gnt", 64'(client_gnt), 64'h0);
    chk("mrst_field", 64'(egress_pkt_field), 64'h0);
    rst = 1'b0;
    egress_ready = 1'b1;
    tick();
    chk("mrst_first_gnt", 64'(client_gnt), 64'h010);
    chk("mrst_first_field", 64'(egress_pkt_field), 64'h000004444);

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
